// File: rtl/video_test_pkg.sv
// rtl/video_test_pkg.sv - shared modes and colour constants for the test-pattern generator
package video_test_pkg;

    typedef enum logic [1:0] {
        MODE_LINES   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_t;

    localparam logic [23:0] COLOR_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h00_00_00;
    localparam logic [23:0] COLOR_RED     = 24'hFF_00_00;
    localparam logic [23:0] COLOR_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] COLOR_GREY    = 24'h80_80_80;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] COLOR_BLUE    = 24'h00_00_FF;

    // Colour-bar palette, bar 0 on the left.
    function automatic logic [23:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return COLOR_WHITE;
            3'd1:    return COLOR_YELLOW;
            3'd2:    return COLOR_CYAN;
            3'd3:    return COLOR_GREEN;
            3'd4:    return COLOR_MAGENTA;
            3'd5:    return COLOR_RED;
            3'd6:    return COLOR_BLUE;
            default: return COLOR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_test_bouncer.sv
// rtl/video_test_bouncer.sv - single-axis bouncing position register with clamped reversal
module video_test_bouncer #(
    parameter int LIMIT = 576,
    parameter int STEP  = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_en,
    output logic [W-1:0] pos
);

    localparam logic [W:0]   STEP_EXT  = (W+1)'(STEP);
    localparam logic [W:0]   LIMIT_EXT = (W+1)'(LIMIT);
    localparam logic [W-1:0] LIMIT_W   = W'(LIMIT);
    localparam logic [W-1:0] STEP_W    = W'(STEP);

    // Low means moving towards LIMIT, high means moving towards 0.
    logic       dir_neg;
    // One extra bit so the forward sum never wraps before the limit compare.
    logic [W:0] next_fwd;

    assign next_fwd = {1'b0, pos} + STEP_EXT;

    // Advance one step per enable, clamping at either end and reversing there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            dir_neg <= 1'b0;
        end else if (step_en) begin
            if (!dir_neg) begin
                if (next_fwd >= LIMIT_EXT) begin
                    pos     <= LIMIT_W;
                    dir_neg <= 1'b1;
                end else begin
                    pos <= next_fwd[W-1:0];
                end
            end else begin
                if (pos <= STEP_W) begin
                    pos     <= '0;
                    dir_neg <= 1'b0;
                end else begin
                    pos <= pos - STEP_W;
                end
            end
        end
    end

endmodule

// File: rtl/video_test_pattern.sv
// rtl/video_test_pattern.sv - registered four-mode video test-pattern generator
module video_test_pattern
    import video_test_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int CELL_SIZE         = 32,
    parameter int BOX_SIZE          = 64,
    parameter int STEP              = 4,
    parameter int FRAME_CNT_WIDTH   = 16,
    localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [X_WIDTH-1:0]         x,
    input  logic [Y_WIDTH-1:0]         y,
    input  logic                       de,
    input  logic                       frame_start,
    input  logic [1:0]                 mode,
    input  logic                       freeze,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b,
    output logic                       de_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    // Wide enough for x*VER and x*8 without overflow.
    localparam int PW        = X_WIDTH + Y_WIDTH + 3;
    localparam int CELL_LOG2 = $clog2(CELL_SIZE);

    localparam logic [PW-1:0] HOR_P = PW'(HOR_ACTIVE_PIXELS);
    localparam logic [PW-1:0] VER_P = PW'(VER_ACTIVE_PIXELS);
    localparam logic [PW-1:0] BOX_P = PW'(BOX_SIZE);

    mode_t               mode_q;
    logic [X_WIDTH-1:0]  box_x;
    logic [Y_WIDTH-1:0]  box_y;
    logic                step_en;

    logic [PW-1:0]       x_p;
    logic [PW-1:0]       y_p;
    logic [PW-1:0]       diag;
    logic [2:0]          bar;
    logic                is_border;
    logic                is_diag;
    logic                in_box;
    logic [23:0]         pix_color;

    assign step_en = frame_start && !freeze;

    video_test_bouncer #(
        .LIMIT (HOR_ACTIVE_PIXELS - BOX_SIZE),
        .STEP  (STEP),
        .W     (X_WIDTH)
    ) u_bounce_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .pos     (box_x)
    );

    video_test_bouncer #(
        .LIMIT (VER_ACTIVE_PIXELS - BOX_SIZE),
        .STEP  (STEP),
        .W     (Y_WIDTH)
    ) u_bounce_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .pos     (box_y)
    );

    // Mode and frame counter change only at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_LINES;
            frame_cnt <= '0;
        end else if (frame_start) begin
            mode_q    <= mode_t'(mode);
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign x_p       = PW'(x);
    assign y_p       = PW'(y);
    assign diag      = (x_p * VER_P) / HOR_P;
    assign bar       = 3'((x_p * PW'(8)) / HOR_P);
    assign is_border = (x_p == '0) || (x_p == HOR_P - 1'b1) ||
                       (y_p == '0) || (y_p == VER_P - 1'b1);
    assign is_diag   = (y_p == diag) || (y_p == VER_P - diag);
    assign in_box    = (x_p >= PW'(box_x)) && (x_p < PW'(box_x) + BOX_P) &&
                       (y_p >= PW'(box_y)) && (y_p < PW'(box_y) + BOX_P);

    // Pattern decode from the current coordinates and the frame's latched mode.
    always_comb begin
        pix_color = COLOR_BLACK;
        case (mode_q)
            MODE_LINES:   pix_color = (is_border || is_diag) ? COLOR_RED : COLOR_WHITE;
            MODE_BARS:    pix_color = bar_color(bar);
            MODE_CHECKER: pix_color = (x[CELL_LOG2] ^ y[CELL_LOG2]) ? COLOR_BLACK : COLOR_WHITE;
            MODE_BOX:     pix_color = in_box ? COLOR_GREEN : COLOR_GREY;
            default:      pix_color = COLOR_BLACK;
        endcase
    end

    // Output register: one cycle of latency, black outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            g    <= '0;
            b    <= '0;
            de_o <= 1'b0;
        end else begin
            de_o      <= de;
            {r, g, b} <= de ? pix_color : COLOR_BLACK;
        end
    end

endmodule

// File: tb/tb_video_test_pattern.sv
// tb/tb_video_test_pattern.sv - directed self-checking bench for video_test_pattern
module tb_video_test_pattern;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de;
    logic        frame_start;
    logic [1:0]  mode;
    logic        freeze;
    logic [7:0]  r, g, b;
    logic        de_o;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_test_pattern dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .de          (de),
        .frame_start (frame_start),
        .mode        (mode),
        .freeze      (freeze),
        .r           (r),
        .g           (g),
        .b           (b),
        .de_o        (de_o),
        .frame_cnt   (frame_cnt)
    );

    task automatic drive_pix(input int px, input int py, input logic pde);
        x           = px[9:0];
        y           = py[8:0];
        de          = pde;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_frames(input int n);
        repeat (n) begin
            de          = 1'b0;
            frame_start = 1'b1;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
        end
    endtask

    task automatic apply_reset();
        de          = 1'b0;
        frame_start = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({r, g, b, de_o} !== 25'd0) begin
            errors++;
            $display("FAIL reset_out: got %06h de_o=%0b expected 000000 de_o=0", {r, g, b}, de_o);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
    endtask

    task automatic test_lines();
        int          px [6] = '{320, 100, 639, 0,   200, 200};
        int          py [6] = '{240, 100, 5,   200, 150, 151};
        logic [23:0] ex [6] = '{24'hFF0000, 24'hFFFFFF, 24'hFF0000,
                                24'hFF0000, 24'hFF0000, 24'hFFFFFF};
        for (int i = 0; i < 6; i++) begin
            drive_pix(px[i], py[i], 1'b1);
            checks++;
            if ({r, g, b} !== ex[i]) begin
                errors++;
                $display("FAIL lines[%0d]: got %06h expected %06h", i, {r, g, b}, ex[i]);
            end
        end
        checks++;
        if (de_o !== 1'b1) begin
            errors++;
            $display("FAIL lines_de_o: got %0b expected 1", de_o);
        end
        drive_pix(200, 330, 1'b1);
        checks++;
        if ({r, g, b} !== 24'hFF0000) begin
            errors++;
            $display("FAIL lines_antidiag: got %06h expected ff0000", {r, g, b});
        end
    endtask

    task automatic test_bars();
        int          px [7] = '{80, 639, 0, 160, 400, 479, 480};
        logic [23:0] ex [7] = '{24'hFFFF00, 24'h000000, 24'hFFFFFF, 24'h00FFFF,
                                24'hFF0000, 24'hFF0000, 24'h0000FF};
        mode = 2'd1;
        do_frames(1);
        for (int i = 0; i < 7; i++) begin
            drive_pix(px[i], 10, 1'b1);
            checks++;
            if ({r, g, b} !== ex[i]) begin
                errors++;
                $display("FAIL bars[%0d]: got %06h expected %06h", i, {r, g, b}, ex[i]);
            end
        end
        drive_pix(80, 10, 1'b0);
        checks++;
        if ({r, g, b, de_o} !== 25'd0) begin
            errors++;
            $display("FAIL bars_blank: got %06h de_o=%0b expected 000000 de_o=0", {r, g, b}, de_o);
        end
    endtask

    task automatic test_checker();
        int          px [6] = '{0, 32, 32, 31, 63, 64};
        int          py [6] = '{0, 0,  32, 31, 0,  0};
        logic [23:0] ex [6] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                                24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        mode = 2'd2;
        do_frames(1);
        for (int i = 0; i < 6; i++) begin
            drive_pix(px[i], py[i], 1'b1);
            checks++;
            if ({r, g, b} !== ex[i]) begin
                errors++;
                $display("FAIL checker[%0d]: got %06h expected %06h", i, {r, g, b}, ex[i]);
            end
        end
    endtask

    task automatic test_box();
        int          p1x [5] = '{416, 415, 416, 479, 480};
        int          p1y [5] = '{416, 416, 415, 479, 416};
        logic [23:0] e1  [5] = '{24'h00FF00, 24'h808080, 24'h808080, 24'h00FF00, 24'h808080};
        int          p2x [5] = '{420, 419, 576, 575, 639};
        int          p2y [5] = '{412, 412, 256, 256, 319};
        logic [23:0] e2  [5] = '{24'h00FF00, 24'h808080, 24'h00FF00, 24'h808080, 24'h00FF00};
        int          p3x [3] = '{572, 571, 572};
        int          p3y [3] = '{252, 252, 251};
        logic [23:0] e3  [3] = '{24'h00FF00, 24'h808080, 24'h808080};
        apply_reset();
        mode   = 2'd3;
        freeze = 1'b0;
        do_frames(104);
        checks++;
        if (frame_cnt !== 16'd104) begin
            errors++;
            $display("FAIL box_frame_cnt104: got %0d expected 104", frame_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive_pix(p1x[i], p1y[i], 1'b1);
            checks++;
            if ({r, g, b} !== e1[i]) begin
                errors++;
                $display("FAIL box_f104[%0d]: got %06h expected %06h", i, {r, g, b}, e1[i]);
            end
        end
        do_frames(1);
        drive_pix(p2x[0], p2y[0], 1'b1);
        checks++;
        if ({r, g, b} !== e2[0]) begin
            errors++;
            $display("FAIL box_f105_in: got %06h expected %06h", {r, g, b}, e2[0]);
        end
        drive_pix(p2x[1], p2y[1], 1'b1);
        checks++;
        if ({r, g, b} !== e2[1]) begin
            errors++;
            $display("FAIL box_f105_out: got %06h expected %06h", {r, g, b}, e2[1]);
        end
        do_frames(39);
        for (int i = 2; i < 5; i++) begin
            drive_pix(p2x[i], p2y[i], 1'b1);
            checks++;
            if ({r, g, b} !== e2[i]) begin
                errors++;
                $display("FAIL box_f144[%0d]: got %06h expected %06h", i, {r, g, b}, e2[i]);
            end
        end
        do_frames(1);
        for (int i = 0; i < 3; i++) begin
            drive_pix(p3x[i], p3y[i], 1'b1);
            checks++;
            if ({r, g, b} !== e3[i]) begin
                errors++;
                $display("FAIL box_f145[%0d]: got %06h expected %06h", i, {r, g, b}, e3[i]);
            end
        end
    endtask

    task automatic test_freeze();
        int          px [4] = '{572, 571, 635, 636};
        int          py [4] = '{252, 252, 315, 315};
        logic [23:0] ex [4] = '{24'h00FF00, 24'h808080, 24'h00FF00, 24'h808080};
        freeze = 1'b1;
        do_frames(10);
        checks++;
        if (frame_cnt !== 16'd155) begin
            errors++;
            $display("FAIL freeze_frame_cnt: got %0d expected 155", frame_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive_pix(px[i], py[i], 1'b1);
            checks++;
            if ({r, g, b} !== ex[i]) begin
                errors++;
                $display("FAIL freeze[%0d]: got %06h expected %06h", i, {r, g, b}, ex[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        mode = 2'd0;
        drive_pix(572, 252, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h00FF00) begin
            errors++;
            $display("FAIL midframe_mode: got %06h expected 00ff00", {r, g, b});
        end
        do_frames(1);
        drive_pix(572, 252, 1'b1);
        checks++;
        if ({r, g, b} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL new_frame_mode: got %06h expected ffffff", {r, g, b});
        end
        checks++;
        if (frame_cnt !== 16'd156) begin
            errors++;
            $display("FAIL mode_frame_cnt: got %0d expected 156", frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        mode   = 2'd3;
        freeze = 1'b1;
        do_frames(1);
        drive_pix(572, 252, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h00FF00) begin
            errors++;
            $display("FAIL pre_reset_pix: got %06h expected 00ff00", {r, g, b});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r, g, b, de_o} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_out: got %06h de_o=%0b expected 000000 de_o=0", {r, g, b}, de_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
        drive_pix(100, 100, 1'b1);
        checks++;
        if ({r, g, b} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL post_reset_mode0: got %06h expected ffffff", {r, g, b});
        end
        do_frames(1);
        drive_pix(0, 0, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h00FF00) begin
            errors++;
            $display("FAIL post_reset_box_origin: got %06h expected 00ff00", {r, g, b});
        end
        drive_pix(64, 0, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h808080) begin
            errors++;
            $display("FAIL post_reset_box_edge: got %06h expected 808080", {r, g, b});
        end
        freeze = 1'b0;
        do_frames(1);
        drive_pix(3, 4, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h808080) begin
            errors++;
            $display("FAIL first_step_out: got %06h expected 808080", {r, g, b});
        end
        drive_pix(4, 4, 1'b1);
        checks++;
        if ({r, g, b} !== 24'h00FF00) begin
            errors++;
            $display("FAIL first_step_in: got %06h expected 00ff00", {r, g, b});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        x           = '0;
        y           = '0;
        de          = 1'b0;
        frame_start = 1'b0;
        mode        = 2'd0;
        freeze      = 1'b0;
        test_reset();
        test_lines();
        test_bars();
        test_checker();
        test_box();
        test_freeze();
        test_mode_change();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_test_pattern.md
# video_test_pattern

Parametrised, registered test-pattern generator for bring-up of the video output path. It sits between the timing generator (which supplies pixel coordinates, active-video and a frame-start strobe) and the encoder. It provides four runtime-selectable patterns, including an animated bouncing box whose position is updated once per frame.

## Interface
- HOR_ACTIVE_PIXELS, 640, active pixels per line
- VER_ACTIVE_PIXELS, 480, active lines per frame
- CELL_SIZE, 32, checkerboard cell edge in pixels; power of two
- BOX_SIZE, 64, bouncing-box edge in pixels; < both active dimensions
- STEP, 4, box displacement per axis per frame; ≥1
- FRAME_CNT_WIDTH, 16, width of the frame counter
- Derived: X_WIDTH = $clog2(HOR_ACTIVE_PIXELS), Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- x  in  X_WIDTH  current pixel column
- y  in  Y_WIDTH  current pixel row
- de  in  1  active video; x and y are valid when high
- frame_start  in  1  one-cycle strobe, asserted in blanking before the first active pixel
- mode  in  2  pattern select, sampled on frame_start
- freeze  in  1  when high, the box does not move on frame_start
- r, g, b  out  8 each  pixel colour, registered
- de_o  out  1  de delayed by one cycle
- frame_cnt  out  FRAME_CNT_WIDTH  frames since reset; wraps

## Operation
- mode_q latches `mode` on each frame_start. It stays constant for the whole frame.
- MODE_LINES (0): background white (255,255,255); border and diagonals red (255,0,0).
  - Border: x==0, x==HOR-1, y==0 or y==VER-1.
  - d = floor(x*VER/HOR). Diagonal when y==d or y==VER-d.
  - Arithmetic is unsigned, at least X_WIDTH+Y_WIDTH bits wide, with constant operands only.
- MODE_BARS (1): bar = floor(x*8/HOR). Colours for bars 0..7: white, yellow, cyan, green, magenta, red, blue, black (components 0 or 255).
- MODE_CHECKER (2): white when (x/CELL_SIZE + y/CELL_SIZE) is even, otherwise black.
- MODE_BOX (3): grey (128,128,128) background; box green (0,255,0).
  - The box covers box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE.
- Box motion happens on frame_start when freeze is low. Each axis is handled independently; X shown, Y is identical with VER:
  - dir_x = +: n = box_x+STEP. If n ≥ HOR-BOX_SIZE, then box_x ← HOR-BOX_SIZE and dir_x ← −. Otherwise box_x ← n.
  - dir_x = −: if box_x ≤ STEP, then box_x ← 0 and dir_x ← +. Otherwise box_x ← box_x−STEP.
- The box always moves regardless of mode_q, so it stays consistent when switching into MODE_BOX.
- frame_cnt increments on every frame_start, whether or not freeze is high. It wraps from all-ones to 0.
- When de is low, the registered output is r=g=b=0.

## Timing
- Latency is 1 cycle: r/g/b/de_o at cycle t+1 reflect x/y/de at cycle t.
- Reset values: r=g=b=0, de_o=0, frame_cnt=0, mode_q=0, box_x=box_y=0, dir_x=dir_y=+.
- Reset asserted mid-frame clears the outputs immediately (asynchronous). After release, the first pixels render with mode 0 until the next frame_start.
- frame_start together with de=1 is a protocol violation. The pixel in that cycle renders with the pre-update mode_q and box position; the updates still occur.
- On frame_start, mode_q, box and frame_cnt all update on the same edge. The new values apply from the next cycle.
- The bounce is clamped: the box never leaves the active area, even when STEP does not divide the travel distance.

## Structure
- Package video_test_pkg holds:
  - mode_t enum (MODE_LINES, MODE_BARS, MODE_CHECKER, MODE_BOX)
  - 24-bit colour constants: white, black, red, green, grey, and the bar colours
- Sub-module video_test_bouncer is a single-axis position/direction register with parameters LIMIT (active size − BOX_SIZE) and STEP, plus ports clk, rst_n, step_en, pos.
  - It is instantiated twice, once per axis.
- The top level holds mode_q, frame_cnt, pattern decode and the output register.

## Test plan
Defaults HOR=640, VER=480.
- Reset then mode 0: x=320,y=240,de=1 → next cycle (255,0,0). x=100,y=100 → (255,255,255). x=639,y=5 → red.
- Mode 1: x=80 → (255,255,0); x=639 → (0,0,0); de=0 → (0,0,0), de_o=0.
- Mode 2: (0,0) → white; (32,0) → black; (32,32) → white.
- Mode 3, 144 frame_starts → box_x=576, dir −; frame 145 → 572. Box_y reaches 416 at frame 104 and reads 412 at frame 105.
- freeze=1 for 10 frames → box unchanged, frame_cnt +10. Mode change mid-frame → no output change until the next frame_start.
- rst_n low mid-line → r/g/b/de_o 0 asynchronously. After release, frame_cnt=0 and box at (0,0).
